// File: rtl/search_pkg.sv
// Shared types and constants for the nonce-search controller.
package search_pkg;

  localparam logic [7:0] TX_PONG   = 8'h70;
  localparam logic [7:0] TX_REPORT = 8'h72;
  localparam int unsigned SCORE_TX_W = 16;

  typedef enum logic [1:0] {
    H_IDLE,
    H_LOAD,
    H_ISSUE,
    H_WAIT
  } h_state_e;

  typedef enum logic [2:0] {
    T_IDLE,
    T_PONG,
    T_HDR,
    T_SCORE,
    T_NONCE
  } t_state_e;

  // Clear every bit above 'width' so a narrow score reads as a 16-bit value.
  function automatic logic [15:0] score_zext(input logic [15:0] raw, input int unsigned width);
    logic [16:0] mask;
    mask = (17'd1 << width) - 17'd1;
    return raw & mask[15:0];
  endfunction

endpackage

// File: rtl/search_controller_if.sv
// Command, hash-core and TX signals of the search controller.
interface search_controller_if #(
  parameter int unsigned NONCE_BYTES = 8,
  parameter int unsigned SCORE_W     = 10
);
  logic                     new_data_i;
  logic [7:0]               data_i;
  logic                     start_i;
  logic                     stop_i;
  logic                     ping_i;
  logic                     nonce_i;
  logic                     nonce_register_ready_o;
  logic                     hash_start_o;
  logic [8*NONCE_BYTES-1:0] hash_nonce_o;
  logic                     hash_done_i;
  logic [SCORE_W-1:0]       hash_score_i;
  logic                     tx_valid_o;
  logic [7:0]               tx_data_o;
  logic                     tx_ready_i;
  logic                     running_o;

  modport slave (
    input  new_data_i, data_i, start_i, stop_i, ping_i, nonce_i,
    input  hash_done_i, hash_score_i, tx_ready_i,
    output nonce_register_ready_o, hash_start_o, hash_nonce_o,
    output tx_valid_o, tx_data_o, running_o
  );

  modport master (
    output new_data_i, data_i, start_i, stop_i, ping_i, nonce_i,
    output hash_done_i, hash_score_i, tx_ready_i,
    input  nonce_register_ready_o, hash_start_o, hash_nonce_o,
    input  tx_valid_o, tx_data_o, running_o
  );
endinterface

// File: rtl/search_controller_report_serializer.sv
// TX framing: 'p' ping replies and 'r' best-result reports over a valid/ready byte port.
module report_serializer
  import search_pkg::*;
#(
  parameter int unsigned NONCE_BYTES = 8,
  parameter int unsigned SCORE_W     = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     ping_req_i,
  input  logic                     report_req_i,
  input  logic [SCORE_W-1:0]       best_score_i,
  input  logic [8*NONCE_BYTES-1:0] best_nonce_i,
  input  logic                     tx_ready_i,
  output logic                     tx_valid_o,
  output logic [7:0]               tx_data_o
);

  localparam int unsigned NONCE_W = 8 * NONCE_BYTES;
  localparam int unsigned CNT_W   = $clog2(NONCE_BYTES + 1);

  t_state_e              state_q;
  logic                  ping_pend_q;
  logic                  rep_pend_q;
  logic [SCORE_TX_W-1:0] snap_score_q;
  logic [NONCE_W-1:0]    snap_nonce_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  valid_q;
  logic [7:0]            data_q;

  // Frame sequencer; a new byte is loaded only when the current one is accepted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= T_IDLE;
      ping_pend_q  <= 1'b0;
      rep_pend_q   <= 1'b0;
      snap_score_q <= '0;
      snap_nonce_q <= '0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
    end else begin
      if (ping_req_i)   ping_pend_q <= 1'b1;
      if (report_req_i) rep_pend_q  <= 1'b1;
      case (state_q)
        T_IDLE: begin
          if (ping_pend_q) begin
            state_q <= T_PONG;
            valid_q <= 1'b1;
            data_q  <= TX_PONG;
          end else if (rep_pend_q) begin
            state_q      <= T_HDR;
            valid_q      <= 1'b1;
            data_q       <= TX_REPORT;
            snap_score_q <= score_zext(16'(best_score_i), SCORE_W);
            snap_nonce_q <= best_nonce_i;
            rep_pend_q   <= report_req_i;
          end
        end
        T_PONG: begin
          if (tx_ready_i) begin
            state_q     <= T_IDLE;
            valid_q     <= 1'b0;
            ping_pend_q <= ping_req_i;
          end
        end
        T_HDR: begin
          if (tx_ready_i) begin
            state_q <= T_SCORE;
            data_q  <= snap_score_q[15:8];
            cnt_q   <= '0;
          end
        end
        T_SCORE: begin
          if (tx_ready_i) begin
            if (cnt_q == '0) begin
              data_q <= snap_score_q[7:0];
              cnt_q  <= CNT_W'(1);
            end else begin
              state_q      <= T_NONCE;
              data_q       <= snap_nonce_q[NONCE_W-1 -: 8];
              snap_nonce_q <= snap_nonce_q << 8;
              cnt_q        <= '0;
            end
          end
        end
        T_NONCE: begin
          if (tx_ready_i) begin
            if (cnt_q == CNT_W'(NONCE_BYTES - 1)) begin
              state_q <= T_IDLE;
              valid_q <= 1'b0;
            end else begin
              data_q       <= snap_nonce_q[NONCE_W-1 -: 8];
              snap_nonce_q <= snap_nonce_q << 8;
              cnt_q        <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= T_IDLE;
      endcase
    end
  end

  assign tx_valid_o = valid_q;
  assign tx_data_o  = data_q;

endmodule

// File: rtl/search_controller.sv
// Nonce-search sequencer: loads the start nonce, issues hashes, tracks the best score.
module search_controller
  import search_pkg::*;
#(
  parameter int unsigned NONCE_BYTES = 8,
  parameter int unsigned SCORE_W     = 10
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  search_controller_if.slave bus
);

  localparam int unsigned NONCE_W = 8 * NONCE_BYTES;
  localparam int unsigned CNT_W   = $clog2(NONCE_BYTES + 1);

  h_state_e           h_state_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [SCORE_W-1:0] best_score_q;
  logic [NONCE_W-1:0] best_nonce_q;
  logic [CNT_W-1:0]   load_cnt_q;
  logic               load_after_q;
  logic               running_q;
  logic               running_d;
  logic               ready_q;
  logic               hash_start_q;
  logic               report_req_q;

  // Run flag: stop and nonce-load override start; start is ignored while a load is owed.
  always_comb begin
    running_d = running_q;
    if (bus.start_i && (h_state_q != H_LOAD) && !load_after_q) running_d = 1'b1;
    if (bus.stop_i || bus.nonce_i) running_d = 1'b0;
  end

  // Hash sequencing FSM with nonce load, result evaluation and nonce increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_state_q    <= H_IDLE;
      nonce_q      <= '0;
      best_score_q <= '1;
      best_nonce_q <= '0;
      load_cnt_q   <= '0;
      load_after_q <= 1'b0;
      running_q    <= 1'b0;
      ready_q      <= 1'b0;
      hash_start_q <= 1'b0;
      report_req_q <= 1'b0;
    end else begin
      ready_q      <= 1'b0;
      hash_start_q <= 1'b0;
      report_req_q <= 1'b0;
      running_q    <= running_d;
      case (h_state_q)
        H_IDLE: begin
          if (bus.nonce_i) begin
            h_state_q  <= H_LOAD;
            load_cnt_q <= '0;
          end else if (running_d) begin
            h_state_q    <= H_ISSUE;
            hash_start_q <= 1'b1;
          end
        end
        H_LOAD: begin
          if (bus.new_data_i) begin
            nonce_q <= NONCE_W'({nonce_q, bus.data_i});
            if (load_cnt_q == CNT_W'(NONCE_BYTES - 1)) begin
              ready_q      <= 1'b1;
              best_score_q <= '1;
              best_nonce_q <= '0;
              h_state_q    <= H_IDLE;
            end else begin
              load_cnt_q <= load_cnt_q + 1'b1;
            end
          end
        end
        H_ISSUE: begin
          if (bus.nonce_i) begin
            h_state_q  <= H_LOAD;
            load_cnt_q <= '0;
          end else begin
            h_state_q <= H_WAIT;
          end
        end
        H_WAIT: begin
          if (bus.hash_done_i) begin
            if (load_after_q || bus.nonce_i) begin
              h_state_q    <= H_LOAD;
              load_cnt_q   <= '0;
              load_after_q <= 1'b0;
            end else begin
              if (bus.hash_score_i < best_score_q) begin
                best_score_q <= bus.hash_score_i;
                best_nonce_q <= nonce_q;
                report_req_q <= 1'b1;
              end
              nonce_q <= nonce_q + 1'b1;
              if (running_d) begin
                h_state_q    <= H_ISSUE;
                hash_start_q <= 1'b1;
              end else begin
                h_state_q <= H_IDLE;
              end
            end
          end else if (bus.nonce_i) begin
            load_after_q <= 1'b1;
          end
        end
        default: h_state_q <= H_IDLE;
      endcase
    end
  end

  report_serializer #(
    .NONCE_BYTES(NONCE_BYTES),
    .SCORE_W    (SCORE_W)
  ) u_report_serializer (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .ping_req_i  (bus.ping_i),
    .report_req_i(report_req_q),
    .best_score_i(best_score_q),
    .best_nonce_i(best_nonce_q),
    .tx_ready_i  (bus.tx_ready_i),
    .tx_valid_o  (bus.tx_valid_o),
    .tx_data_o   (bus.tx_data_o)
  );

  assign bus.nonce_register_ready_o = ready_q;
  assign bus.hash_start_o           = hash_start_q;
  assign bus.hash_nonce_o           = nonce_q;
  assign bus.running_o              = running_q;

endmodule

// File: tb/tb_search_controller.sv
// Directed bench for search_controller: nonce load, search, wrap, TX framing, stop, reset.
module tb_search_controller;

  localparam int NB = 8;
  localparam int SW = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  search_controller_if #(.NONCE_BYTES(NB), .SCORE_W(SW)) bus ();

  search_controller #(.NONCE_BYTES(NB), .SCORE_W(SW)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int hs_count = 0;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  typedef struct {
    logic [SW-1:0] score;
    logic [63:0]   exp_nonce;
    logic          stop;
  } hvec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // TX capture, hold-stability check and hash_start counting, away from the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("tx hold valid", 64'(bus.tx_valid_o), 64'd1);
        chk("tx hold data", 64'(bus.tx_data_o), 64'(prev_data));
      end
      if (bus.tx_valid_o && bus.tx_ready_i) rxq.push_back(bus.tx_data_o);
      if (bus.hash_start_o) hs_count++;
      prev_stall = bus.tx_valid_o && !bus.tx_ready_i;
      prev_data  = bus.tx_data_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_nonce(input logic [63:0] v);
    bus.nonce_i = 1'b1;
    tick();
    bus.nonce_i = 1'b0;
    for (int i = 0; i < NB; i++) begin
      bus.data_i     = v[8*(NB-1-i) +: 8];
      bus.new_data_i = 1'b1;
      tick();
      bus.new_data_i = 1'b0;
      if (i < NB - 1) begin
        chk("ready before last byte", 64'(bus.nonce_register_ready_o), 64'd0);
        chk("running during load", 64'(bus.running_o), 64'd0);
        tick();
      end
    end
    chk("nonce ready pulse", 64'(bus.nonce_register_ready_o), 64'd1);
    tick();
    chk("nonce ready one cycle", 64'(bus.nonce_register_ready_o), 64'd0);
    chk("loaded nonce", 64'(bus.hash_nonce_o), v);
  endtask

  task automatic wait_start;
    for (int i = 0; i < 20 && bus.hash_start_o !== 1'b1; i++) tick();
    chk("hash_start seen", 64'(bus.hash_start_o), 64'd1);
  endtask

  task automatic finish_hash(input logic [SW-1:0] score, input logic with_stop, input logic [63:0] n);
    tick();
    chk("hash_start one cycle", 64'(bus.hash_start_o), 64'd0);
    tick();
    tick();
    chk("nonce stable in wait", 64'(bus.hash_nonce_o), n);
    bus.hash_done_i  = 1'b1;
    bus.hash_score_i = score;
    bus.stop_i       = with_stop;
    tick();
    bus.hash_done_i  = 1'b0;
    bus.hash_score_i = '0;
    bus.stop_i       = 1'b0;
  endtask

  task automatic run_one(input logic [63:0] n, input logic [SW-1:0] score);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    wait_start();
    chk("single hash nonce", 64'(bus.hash_nonce_o), n);
    finish_hash(score, 1'b1, n);
  endtask

  task automatic push_report(input logic [15:0] s, input logic [63:0] n);
    expq.push_back(8'h72);
    expq.push_back(s[15:8]);
    expq.push_back(s[7:0]);
    for (int i = 0; i < NB; i++) expq.push_back(n[8*(NB-1-i) +: 8]);
  endtask

  task automatic check_frames(input string nm);
    int m;
    for (int i = 0; i < 80; i++) tick();
    chk({nm, " byte count"}, 64'(rxq.size()), 64'(expq.size()));
    m = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s byte %0d", nm, i), 64'(rxq[i]), 64'(expq[i]));
    rxq.delete();
    expq.delete();
  endtask

  initial begin
    hvec_t hv[3];
    int    hs_before;
    hv[0] = '{score: 10'd500, exp_nonce: 64'h100, stop: 1'b0};
    hv[1] = '{score: 10'd400, exp_nonce: 64'h101, stop: 1'b0};
    hv[2] = '{score: 10'd450, exp_nonce: 64'h102, stop: 1'b1};

    bus.new_data_i = 1'b0; bus.data_i = '0; bus.start_i = 1'b0; bus.stop_i = 1'b0;
    bus.ping_i = 1'b0; bus.nonce_i = 1'b0; bus.hash_done_i = 1'b0; bus.hash_score_i = '0;
    bus.tx_ready_i = 1'b1;

    // Reset state
    tick(); tick();
    chk("reset hash_start", 64'(bus.hash_start_o), 64'd0);
    chk("reset ready", 64'(bus.nonce_register_ready_o), 64'd0);
    chk("reset tx_valid", 64'(bus.tx_valid_o), 64'd0);
    chk("reset running", 64'(bus.running_o), 64'd0);
    chk("reset nonce", 64'(bus.hash_nonce_o), 64'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Nonce load and table-driven search
    load_nonce(64'h0000_0000_0000_0100);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk("running after start", 64'(bus.running_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) wait_start();
      else chk($sformatf("hash_start after done %0d", i), 64'(bus.hash_start_o), 64'd1);
      chk($sformatf("search nonce %0d", i), 64'(bus.hash_nonce_o), hv[i].exp_nonce);
      finish_hash(hv[i].score, hv[i].stop, hv[i].exp_nonce);
    end
    hs_before = hs_count;
    for (int i = 0; i < 10; i++) tick();
    chk("no hash after stop", 64'(hs_count - hs_before), 64'd0);
    chk("running after stop", 64'(bus.running_o), 64'd0);
    push_report(16'h01F4, 64'h100);
    push_report(16'h0190, 64'h101);
    check_frames("search frames");

    // Nonce wrap
    load_nonce(64'hFFFF_FFFF_FFFF_FFFF);
    run_one(64'hFFFF_FFFF_FFFF_FFFF, 10'd1000);
    chk("nonce wrap", 64'(bus.hash_nonce_o), 64'd0);
    push_report(16'h03E8, 64'hFFFF_FFFF_FFFF_FFFF);
    check_frames("wrap frame");

    // Mid-frame pings with toggling ready
    load_nonce(64'h10);
    run_one(64'h10, 10'd7);
    for (int i = 0; i < 20 && bus.tx_valid_o !== 1'b1; i++) tick();
    chk("report frame started", 64'(bus.tx_valid_o), 64'd1);
    for (int i = 0; i < 40; i++) begin
      bus.tx_ready_i = (i % 2 == 0);
      bus.ping_i     = (i == 3 || i == 6);
      tick();
      bus.ping_i = 1'b0;
    end
    bus.tx_ready_i = 1'b1;
    push_report(16'h0007, 64'h10);
    expq.push_back(8'h70);
    check_frames("ping after frame");

    // Stop while hash in flight
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    wait_start();
    chk("stop test nonce", 64'(bus.hash_nonce_o), 64'h11);
    tick();
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    chk("running cleared by stop", 64'(bus.running_o), 64'd0);
    tick();
    bus.hash_done_i  = 1'b1;
    bus.hash_score_i = 10'd3;
    tick();
    bus.hash_done_i  = 1'b0;
    bus.hash_score_i = '0;
    hs_before = hs_count;
    push_report(16'h0003, 64'h11);
    check_frames("stop frame");
    chk("no hash after stopped done", 64'(hs_count - hs_before), 64'd0);
    chk("running after stopped done", 64'(bus.running_o), 64'd0);

    // Start and stop together
    hs_before = hs_count;
    bus.start_i = 1'b1;
    bus.stop_i  = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    chk("start+stop running", 64'(bus.running_o), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("start+stop no hash", 64'(hs_count - hs_before), 64'd0);

    // Reset in the middle of a stalled frame
    run_one(64'h12, 10'd2);
    bus.tx_ready_i = 1'b0;
    for (int i = 0; i < 20 && bus.tx_valid_o !== 1'b1; i++) tick();
    chk("stalled frame valid", 64'(bus.tx_valid_o), 64'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset tx_valid", 64'(bus.tx_valid_o), 64'd0);
    chk("async reset nonce", 64'(bus.hash_nonce_o), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    bus.tx_ready_i = 1'b1;
    rxq.delete();
    expq.delete();
    for (int i = 0; i < 20; i++) tick();
    chk("no frame after reset", 64'(rxq.size()), 64'd0);
    run_one(64'h0, 10'h3FF);
    run_one(64'h1, 10'h3FE);
    push_report(16'h03FE, 64'h1);
    check_frames("post-reset best");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
